// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG word packer.
package trng_pkg;

   // Packer control states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_ALARM   = 2'd2
   } packer_state_e;

   localparam int unsigned DEF_WORD_W     = 32;
   localparam int unsigned DEF_FIFO_DEPTH = 4;
   localparam int unsigned DEF_RCT_CUTOFF = 16;

endpackage

// File: rtl/trng_word_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra MSB so
// that equal addresses can be told apart as "full" or "empty".
module trng_word_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push_i,
   input  logic [WIDTH-1:0]               push_data_i,
   input  logic                           pop_i,
   output logic [WIDTH-1:0]               rd_data_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
   assign do_push = push_i && (!full_o || do_pop);

   assign count_o   = CNT_W'(wr_ptr_q - rd_ptr_q);
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

   // Pointer next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Word storage
   // NOTE: storage is left unreset; the read mux forces 0 while empty, so stale
   // entries are never visible after reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/trng_word_packer.sv
// Packs corrected TRNG bits LSB-first into words, screens the stream with a
// repetition-count test and buffers completed words in a FWFT FIFO.
module trng_word_packer
   import trng_pkg::*;
#(
   parameter int unsigned WORD_W     = DEF_WORD_W,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned RCT_CUTOFF = DEF_RCT_CUTOFF
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                enable,
   input  logic                                bit_in,
   input  logic                                bit_valid,
   input  logic                                word_ready,
   input  logic                                clear_alarm,
   output logic [WORD_W-1:0]                   word_out,
   output logic                                word_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
   output logic                                alarm,
   output logic                                overflow
);

   localparam int unsigned      IDX_W    = $clog2(WORD_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
   localparam logic [7:0]       RC_CUT   = 8'(RCT_CUTOFF);

   packer_state_e     state_q, state_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        rc_q, rc_d;
   logic              last_q, last_d;
   logic              alarm_q, alarm_d;
   logic              overflow_q, overflow_d;

   logic              push_req;
   logic [WORD_W-1:0] push_word;
   logic              trip;
   logic              fifo_full, fifo_empty, pop;

   assign word_valid = !fifo_empty;
   assign pop        = word_valid && word_ready;
   assign alarm      = alarm_q;
   assign overflow   = overflow_q;

   // FSM next-state, bit packing, repetition-count test and sticky flags
   // NOTE: every variable gets a default first so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      idx_d      = idx_q;
      rc_d       = rc_q;
      last_d     = last_q;
      alarm_d    = alarm_q;
      overflow_d = overflow_q;
      push_req   = 1'b0;
      push_word  = word_q;
      trip       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (enable && !alarm_q) state_d = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (bit_valid) begin
               word_d[idx_q] = bit_in;
               last_d        = bit_in;
               if (rc_q == 8'd0 || bit_in != last_q) rc_d = 8'd1;
               else if (rc_q < RC_CUT)               rc_d = rc_q + 8'd1;

               if (rc_d == RC_CUT) begin
                  // Trip discards the partial word, including one completed by this bit.
                  trip    = 1'b1;
                  state_d = ST_ALARM;
                  alarm_d = 1'b1;
                  word_d  = '0;
                  idx_d   = '0;
               end else if (idx_q == IDX_LAST) begin
                  push_req  = 1'b1;
                  push_word = word_d;
                  word_d    = '0;
                  idx_d     = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_ALARM: begin
            if (clear_alarm) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A coincident trip keeps the alarm set.
      if (clear_alarm) begin
         overflow_d = 1'b0;
         if (!trip) begin
            alarm_d = 1'b0;
            idx_d   = '0;
            rc_d    = 8'd0;
         end
      end

      if (!enable) begin
         word_d = '0;
         idx_d  = '0;
         rc_d   = 8'd0;
      end

      if (push_req && fifo_full && !pop) overflow_d = 1'b1;
   end

   // State and datapath registers
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         idx_q      <= '0;
         rc_q       <= 8'd0;
         last_q     <= 1'b0;
         alarm_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         rc_q       <= rc_d;
         last_q     <= last_d;
         alarm_q    <= alarm_d;
         overflow_q <= overflow_d;
      end
   end

   trng_word_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_req),
      .push_data_i (push_word),
      .pop_i       (word_ready),
      .rd_data_o   (word_out),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_trng_word_packer.sv
// Directed bench for trng_word_packer with a queue-based reference model.
module tb_trng_word_packer;

   localparam int WORD_W = 32;
   localparam int DEPTH  = 4;
   localparam int CUT    = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        bit_in = 1'b0;
   logic        bit_valid = 1'b0;
   logic        word_ready = 1'b0;
   logic        clear_alarm = 1'b0;
   logic [31:0] word_out;
   logic        word_valid;
   logic [2:0]  fifo_count;
   logic        alarm;
   logic        overflow;

   int n_vec = 0;
   int n_err = 0;

   trng_word_packer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .word_ready  (word_ready),
      .clear_alarm (clear_alarm),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .fifo_count  (fifo_count),
      .alarm       (alarm),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int M_IDLE = 0, M_COLLECT = 1, M_ALARM = 2;
   int          m_mode = M_IDLE;
   bit          m_alarm = 0;
   bit          m_ovf = 0;
   int          m_run = 0;
   bit          m_last = 0;
   bit          m_bits[$];
   logic [31:0] m_fifo[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_IDLE; m_alarm = 0; m_ovf = 0; m_run = 0; m_last = 0;
         m_bits.delete(); m_fifo.delete();
      end else begin
         bit          pop_m, trip, done;
         logic [31:0] w;
         int          next_mode;
         pop_m = (m_fifo.size() != 0) && word_ready;
         trip = 0; done = 0; w = '0;
         if (m_mode == M_COLLECT && enable && bit_valid) begin
            m_bits.push_back(bit_in);
            if (m_run == 0 || bit_in != m_last) m_run = 1;
            else if (m_run < CUT)                 m_run++;
            m_last = bit_in;
            if (m_run == CUT) begin
               trip = 1;
               m_bits.delete();
            end else if (m_bits.size() == WORD_W) begin
               done = 1;
               foreach (m_bits[i]) w = w + (32'(m_bits[i]) << i);
               m_bits.delete();
            end
         end
         next_mode = m_mode;
         if (m_mode == M_IDLE && enable && !m_alarm)       next_mode = M_COLLECT;
         else if (m_mode == M_COLLECT && !enable)          next_mode = M_IDLE;
         else if (m_mode == M_COLLECT && trip)             next_mode = M_ALARM;
         else if (m_mode == M_ALARM && clear_alarm)        next_mode = M_IDLE;
         m_mode = next_mode;
         if (trip) m_alarm = 1;
         if (clear_alarm) begin
            m_ovf = 0;
            if (!trip) begin m_alarm = 0; m_bits.delete(); m_run = 0; end
         end
         if (!enable) begin m_bits.delete(); m_run = 0; end
         if (pop_m) void'(m_fifo.pop_front());
         if (done) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else                       m_ovf = 1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      check("word_valid", 32'(word_valid), 32'(m_fifo.size() != 0));
      check("word_out", word_out, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
      check("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
      check("alarm", 32'(alarm), 32'(m_alarm));
      check("overflow", 32'(overflow), 32'(m_ovf));
   end

   // ---------------- stimulus helpers ----------------
   task automatic feed_bits(input logic [31:0] w, input int n, input bit pop_on_last);
      for (int i = 0; i < n; i++) begin
         bit_in     = w[i];
         bit_valid  = 1'b1;
         word_ready = pop_on_last && (i == n - 1);
         @(posedge clk); #1;
      end
      bit_valid  = 1'b0;
      word_ready = 1'b0;
   endtask

   task automatic pop_word(input string name, input logic [31:0] exp);
      check(name, word_out, exp);
      word_ready = 1'b1;
      @(posedge clk); #1;
      word_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_alarm = 1'b1;
      @(posedge clk); #1;
      clear_alarm = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      repeat (2) @(posedge clk); #1;
      check("rst word_valid", 32'(word_valid), 32'h0);
      check("rst word_out", word_out, 32'h0);
      check("rst fifo_count", 32'(fifo_count), 32'h0);
      check("rst alarm", 32'(alarm), 32'h0);
      check("rst overflow", 32'(overflow), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Pack alternating bits
      enable = 1'b1;
      @(posedge clk); #1;
      feed_bits(32'hAAAA_AAAA, 31, 0);
      check("pre-last word_valid", 32'(word_valid), 32'h0);
      feed_bits(32'h1, 1, 0);
      check("pack word_valid", 32'(word_valid), 32'h1);
      check("pack word_out", word_out, 32'hAAAA_AAAA);
      check("pack fifo_count", 32'(fifo_count), 32'h1);
      check("pack alarm", 32'(alarm), 32'h0);
      pop_word("pack pop", 32'hAAAA_AAAA);
      check("pack drained", 32'(fifo_count), 32'h0);

      // Backpressure and overflow
      feed_bits(32'h1234_5678, 32, 0);
      feed_bits(32'hCAFE_BABE, 32, 0);
      feed_bits(32'h0F0F_0F0F, 32, 0);
      feed_bits(32'h55AA_55AA, 32, 0);
      check("full no ovf", 32'(overflow), 32'h0);
      feed_bits(32'h1357_9BDF, 32, 0);
      check("ovf fifo_count", 32'(fifo_count), 32'h4);
      check("ovf flag", 32'(overflow), 32'h1);
      check("ovf head", word_out, 32'h1234_5678);
      pulse_clear();
      check("ovf cleared", 32'(overflow), 32'h0);

      // Simultaneous push and pop while full
      feed_bits(32'h2468_ACE0, 32, 1);
      check("pushpop count", 32'(fifo_count), 32'h4);
      check("pushpop ovf", 32'(overflow), 32'h0);
      pop_word("read w2", 32'hCAFE_BABE);
      pop_word("read w3", 32'h0F0F_0F0F);
      pop_word("read w4", 32'h55AA_55AA);
      pop_word("read w6", 32'h2468_ACE0);
      check("read empty", 32'(word_valid), 32'h0);

      // Repetition-count trip after 5 packed bits
      feed_bits(32'b00101, 5, 0);
      feed_bits(32'h0000_FFFF, 15, 0);
      check("rct pre-trip", 32'(alarm), 32'h0);
      feed_bits(32'h1, 1, 0);
      check("rct alarm", 32'(alarm), 32'h1);
      feed_bits(32'h0001_2345, 20, 0);
      check("rct ignored", 32'(fifo_count), 32'h0);
      pulse_clear();
      check("rct cleared", 32'(alarm), 32'h0);
      @(posedge clk); #1;
      feed_bits(32'h3C3C_3C3C, 32, 0);
      check("rct fresh word", word_out, 32'h3C3C_3C3C);
      check("rct fresh count", 32'(fifo_count), 32'h1);

      // enable drop mid-word
      feed_bits(32'h0000_02AA, 10, 0);
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1 enable = 1'b1;
      @(posedge clk); #1;
      feed_bits(32'h600D_F00D, 32, 0);
      check("en count", 32'(fifo_count), 32'h2);
      pop_word("en retained", 32'h3C3C_3C3C);
      pop_word("en post word", 32'h600D_F00D);

      // Async reset mid-word with two words buffered
      feed_bits(32'h9E37_79B9, 32, 0);
      feed_bits(32'h7F4A_7C15, 32, 0);
      check("pre-rst count", 32'(fifo_count), 32'h2);
      feed_bits(32'h5, 7, 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst word_valid", 32'(word_valid), 32'h0);
      check("arst word_out", word_out, 32'h0);
      check("arst fifo_count", 32'(fifo_count), 32'h0);
      check("arst alarm", 32'(alarm), 32'h0);
      check("arst overflow", 32'(overflow), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("post-rst count", 32'(fifo_count), 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      feed_bits(32'hDEAD_BEEF, 32, 0);
      check("post-rst word", word_out, 32'hDEAD_BEEF);
      check("post-rst count1", 32'(fifo_count), 32'h1);

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/trng_word_packer.md
# trng_word_packer

Consumer end of the TRNG bit stream. It takes debiased single bits from the Von Neumann corrector as a `bit_in`/`bit_valid` pair and packs them into WORD_W-bit words. It screens the stream with a repetition-count health test and buffers completed words in a small FIFO. Words are served to the bus side through a valid/ready handshake.

## Interface
- WORD_W, 32, bits per output word (≥ 2)
- FIFO_DEPTH, 4, number of buffered words (power of 2, ≥ 2)
- RCT_CUTOFF, 16, identical consecutive bits that trip the alarm (2..255)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  packer/health-test enable; FIFO is unaffected
- bit_in  in  1  corrected random bit
- bit_valid  in  1  bit_in is valid this cycle (single-cycle strobe)
- word_ready  in  1  consumer accepts word_out this cycle
- clear_alarm  in  1  single-cycle strobe, clears alarm and overflow
- word_out  out  WORD_W  head-of-FIFO word
- word_valid  out  1  FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words currently stored
- alarm  out  1  sticky: repetition-count test failed
- overflow  out  1  sticky: completed word dropped because FIFO full

## Operation
- States: IDLE (enable=0), COLLECT, ALARM.
  - IDLE→COLLECT when enable=1 and alarm=0.
  - COLLECT→ALARM when the RCT trips.
  - ALARM→IDLE on clear_alarm.
  - Any state→IDLE when enable=0, except ALARM, which holds until clear_alarm.
- COLLECT:
  - Each bit_valid writes bit_in at position bit_idx. Packing is LSB-first: the first bit lands in bit 0.
  - bit_idx increments each accepted bit; on the WORD_W-th bit the word completes and bit_idx wraps to 0.
- RCT:
  - Tracks last_bit and run length rc (8-bit).
  - A bit equal to last_bit increments rc, saturating at RCT_CUTOFF. A different bit sets rc=1.
  - The first bit after entering COLLECT sets rc=1.
  - When rc reaches RCT_CUTOFF: alarm=1, partial word discarded, bit_idx=0, state ALARM.
  - A word completed by the tripping bit is not pushed.
- ALARM: bit_valid is ignored. FIFO contents stay readable.
- enable=0: bit_idx, rc and the partial word are cleared. FIFO, alarm and overflow are retained.
- Push: a completed word is pushed if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the word is dropped and overflow=1.
- Pop: occurs when word_valid && word_ready. word_out is first-word fall-through: it shows the head word whenever word_valid=1 and is 0 when the FIFO is empty.
- Simultaneous push and pop: both take effect; fifo_count is unchanged.
- clear_alarm: clears alarm, overflow, bit_idx and rc. It does not flush the FIFO. If it coincides with a trip, the trip wins and alarm stays 1.

## Timing
- Reset values: word_out=0, word_valid=0, fifo_count=0, alarm=0, overflow=0, state IDLE, bit_idx=0, rc=0.
- Latency: the WORD_W-th bit_valid in cycle N gives word_valid=1 and the new word_out in cycle N+1, when the FIFO was empty.
- A pop in cycle N updates word_out/fifo_count in cycle N+1.
- alarm and overflow assert the cycle after the causing event.
- clear_alarm in cycle N deasserts alarm in N+1. With enable=1, the packer accepts bits from N+2.
- rst_n asserted mid-word or mid-handshake returns every register to its reset value immediately; no partial word survives.
- Back-to-back bit_valid every cycle is supported at full rate.

## Structure
- Shared package trng_pkg holds:
  - packer state encoding (IDLE, COLLECT, ALARM)
  - default WORD_W, FIFO_DEPTH and RCT_CUTOFF constants
- Sub-module trng_word_fifo:
  - parameterised synchronous FWFT FIFO with async active-low reset
  - push/pop/full/empty/count
  - pointers of $clog2(FIFO_DEPTH)+1 bits; the extra MSB distinguishes full from empty
- Top holds the FSM, shift register, bit_idx and RCT logic.

## Test plan
- Reset and pack: enable=1, feed 32 alternating bits 0,1,0,1… → word_out=32'hAAAAAAAA, word_valid=1 one cycle after the last bit, fifo_count=1, alarm=0.
- Backpressure/overflow: word_ready=0, push 5 words with DEPTH=4 → fifo_count=4, overflow=1. The 5th word is lost; reads return words 1–4 in order.
- Simultaneous push/pop at full: with fifo_count=4, complete a word in the same cycle as word_ready=1 → count stays 4, overflow=0, new word appears last.
- RCT trip: 16 consecutive 1s after 5 packed bits → alarm=1, partial word discarded, further bits ignored. clear_alarm → alarm=0, the next 32 bits form a fresh word.
- enable drop mid-word: 10 bits, enable=0 for 3 cycles, enable=1, then 32 bits → the first output word contains only the post-enable bits. FIFO content from before the drop is retained.
- Async reset mid-word with fifo_count=2 → all outputs 0 immediately, fifo_count=0 after release.
